// File: rtl/satellite_uart_rx.sv
// Purpose: 8N1 UART receiver for the satellite controller link, presenting bytes on an AXI-Stream style output.
// Latency: tvalid rises one cycle after the stop-bit sample (about 9.5 bit times after the start edge, plus 2 sync cycles).
// Backpressure: single output register; a byte that completes while tvalid && !tready is dropped and overrun pulses.
//
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset (release synchronised externally)
//   satellite_uart_rxd         asynchronous serial input, idle high, LSB first
//   m_axis_tdata/tvalid/tready received byte and its valid/ready handshake
//   frame_err                  one-cycle pulse when the stop bit is sampled low
//   overrun                    one-cycle pulse when a completed byte is dropped
//   busy                       receive FSM is not idle
module satellite_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       satellite_uart_rxd,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             sync_q, rx_s;
    logic             tick;
    logic             byte_done;
    logic             stop_err;

    // Two-flop synchroniser; reset to the idle (high) level so a line held
    // low through reset is only seen as a start once it propagates through.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= satellite_uart_rxd;
            rx_s   <= sync_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
        end
    end

    assign tick = (cnt == '0);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        byte_done   = 1'b0;
        stop_err    = 1'b0;
        case (state)
            IDLE: begin
                // Half-bit load so every later sample lands mid-bit.
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        cnt_nxt     = FULL_LOAD;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nxt[bit_idx] = rx_s;
                    cnt_nxt            = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stop_err  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            WAIT_IDLE: begin
                // A low stop bit may be a break; wait for the line to return
                // high before arming start detection again.
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output register: a completed byte is taken if the register is empty or
    // draining this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= byte_done && m_axis_tvalid && !m_axis_tready;
            if (byte_done && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= shift_reg;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_satellite_uart_rx.sv
module tb_satellite_uart_rx;

    localparam int C = 16;
    localparam int H = C / 2;

    typedef struct {
        int         t;
        bit         err;
        logic [7:0] b;
    } ev_t;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       rxd;
    logic       tready;
    logic [7:0] tdata;
    logic       tvalid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 aclk = ~aclk;

    satellite_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .satellite_uart_rxd (rxd),
        .m_axis_tdata       (tdata),
        .m_axis_tvalid      (tvalid),
        .m_axis_tready      (tready),
        .frame_err          (frame_err),
        .overrun            (overrun),
        .busy               (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    ev_t        evq[$];
    logic [7:0] acc_log[$];
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Called at a negedge. The start bit reaches the receiver two edges later
    // (synchroniser), is detected one edge after that, and the stop bit is
    // sampled half a bit plus nine full bits after detection.
    task automatic send(input logic [7:0] b, input bit stop_lvl, input int stop_len,
                        input bit expect_ev);
        ev_t e;
        if (expect_ev) begin
            e.t   = cyc + 3 + H + 9 * C;
            e.err = !stop_lvl;
            e.b   = b;
            evq.push_back(e);
        end
        rxd = 1'b0;
        repeat (C) @(negedge aclk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge aclk);
        end
        rxd = stop_lvl;
        repeat (stop_len) @(negedge aclk);
        rxd = 1'b1;
    endtask

    // Reference model of the output stage driven by expected frame events;
    // compared with the DUT 1 time unit after every rising edge.
    initial begin : compare
        bit         rdy, done, x_ferr, x_ovr, ev_v, prev_v;
        logic [7:0] ev_d, prev_d, nb;
        ev_t        e;
        ev_v = 0; ev_d = 8'h00; prev_v = 0; prev_d = 8'h00; nb = 8'h00;
        forever begin
            @(posedge aclk);
            cyc++;
            rdy    = tready;
            x_ferr = 0;
            x_ovr  = 0;
            done   = 0;
            if (aresetn) begin
                if (prev_v && rdy) acc_log.push_back(prev_d);
                if (evq.size() > 0 && evq[0].t == cyc) begin
                    e = evq.pop_front();
                    if (e.err) x_ferr = 1;
                    else begin
                        done = 1;
                        nb   = e.b;
                    end
                end
                if (done) begin
                    if (!ev_v || rdy) begin
                        ev_v = 1;
                        ev_d = nb;
                    end else begin
                        x_ovr = 1;
                    end
                end else if (ev_v && rdy) begin
                    ev_v = 0;
                end
            end
            #1;
            if (!aresetn) begin
                ev_v = 0;
                ev_d = 8'h00;
                check("rst_tvalid", tvalid, 0);
                check("rst_tdata", tdata, 0);
                check("rst_frame_err", frame_err, 0);
                check("rst_overrun", overrun, 0);
                check("rst_busy", busy, 0);
            end else begin
                check("tvalid", tvalid, ev_v);
                if (ev_v) check("tdata", tdata, ev_d);
                check("frame_err", frame_err, x_ferr);
                check("overrun", overrun, x_ovr);
            end
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            prev_v = tvalid;
            prev_d = tdata;
        end
    end

    initial begin : main
        int         s2;
        logic [7:0] exp_log [6];
        exp_log = '{8'hA5, 8'h81, 8'h11, 8'h55, 8'hAA, 8'h0F};
        aresetn = 1'b0;
        rxd     = 1'b1;
        tready  = 1'b1;
        idle(5);
        aresetn = 1'b1;
        idle(20);

        // Plain byte with ready held high.
        send(8'hA5, 1'b1, C, 1'b1);
        idle(20);

        // Six-cycle low glitch: must be rejected at the start-bit midpoint.
        rxd = 1'b0;
        idle(6);
        rxd = 1'b1;
        check("glitch_busy_hi", busy, 1);
        idle(10);
        check("glitch_busy_lo", busy, 0);
        idle(10);

        // Low stop bit held 20 cycles, then a good byte.
        send(8'h3C, 1'b0, 20, 1'b1);
        check("wait_idle_busy", busy, 1);
        idle(5);
        check("after_wait_busy", busy, 0);
        send(8'h81, 1'b1, C, 1'b1);
        idle(20);

        // Output stalled: second byte dropped with overrun.
        tready = 1'b0;
        send(8'h11, 1'b1, C, 1'b1);
        send(8'h22, 1'b1, C, 1'b1);
        idle(5);
        check("stall_tdata", tdata, 8'h11);
        tready = 1'b1;
        idle(5);
        check("drain_tvalid", tvalid, 0);

        // Back-to-back with a single ready pulse on the second completion.
        tready = 1'b0;
        s2 = cyc + 10 * C + 3 + H + 9 * C;
        fork
            begin
                send(8'h55, 1'b1, C, 1'b1);
                send(8'hAA, 1'b1, C, 1'b1);
            end
            begin
                while (cyc != s2 - 1) @(negedge aclk);
                tready = 1'b1;
                @(negedge aclk);
                tready = 1'b0;
            end
        join
        idle(10);
        check("b2b_tdata", tdata, 8'hAA);
        check("b2b_tvalid", tvalid, 1);
        tready = 1'b1;
        idle(10);

        // Reset in the middle of data bit 4 of 0xF0: frame must vanish.
        fork
            send(8'hF0, 1'b1, C, 1'b0);
            begin
                idle(5 * C + H);
                aresetn = 1'b0;
                idle(3);
                aresetn = 1'b1;
            end
        join
        idle(10);
        send(8'h0F, 1'b1, C, 1'b1);
        idle(20);

        check("accept_count", acc_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_log.size()) check("accept_byte", acc_log[i], exp_log[i]);
        end
        check("frame_err_pulses", ferr_cnt, 1);
        check("overrun_pulses", ovr_cnt, 1);
        check("events_left", evq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/satellite_uart_rx.md
SATELLITE_UART_RX -- requirements
Module: satellite_uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving aclk cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 aclk  input  1  sole clock; all logic on rising edge.
REQ-003 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-004 satellite_uart_rxd  input  1  asynchronous serial line from satellite controller, idle high, 8N1, LSB first.
REQ-005 m_axis_tdata  output  8  received byte.
REQ-006 m_axis_tvalid  output  1  tdata holds an unconsumed byte.
REQ-007 m_axis_tready  input  1  consumer accepts byte when high with tvalid.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: byte completed while output register full and not draining.
REQ-010 busy  output  1  high whenever the receive FSM is not in IDLE.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all decisions use the second flop (rx_s).
REQ-012 Bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, counting down; a "tick" is counter == 0.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: on rx_s == 0, go to START, load counter with CLKS_PER_BIT/2 - 1 (integer divide).
REQ-015 START at tick: rx_s == 0 -> DATA, counter = CLKS_PER_BIT - 1, bit index = 0; rx_s == 1 -> IDLE, no error flagged (glitch rejection).
REQ-016 DATA at tick: shift rx_s into bit[index] (LSB first), reload counter CLKS_PER_BIT - 1; after index 7 go to STOP.
REQ-017 STOP at tick: rx_s == 1 -> byte complete, go to IDLE; rx_s == 0 -> frame_err pulse, byte discarded, go to WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s == 1, then IDLE; no start detection while in WAIT_IDLE.
REQ-019 On byte complete with tvalid == 0, tdata SHALL load the byte and tvalid SHALL assert the following cycle (latency: 1 cycle after stop-bit sample cycle).
REQ-020 Handshake: tvalid && tready in a cycle SHALL clear tvalid next cycle unless a new byte completes in the same cycle.
REQ-021 Byte complete with tvalid && tready in same cycle SHALL load the new byte, keep tvalid high, no overrun.
REQ-022 Byte complete with tvalid && !tready SHALL drop the new byte, keep old tdata/tvalid, pulse overrun.
REQ-023 tdata and tvalid SHALL not change while tvalid && !tready except per REQ-022 (never).
REQ-024 frame_err and overrun SHALL never both assert in one cycle (frame errors discard before output stage).
REQ-025 busy SHALL be combinational from FSM state (state != IDLE).

Reset
REQ-026 On aresetn low: FSM = IDLE, counter = 0, bit index = 0, shift register = 0, synchronizer flops = 1, tdata = 0x00, tvalid = 0, frame_err = 0, overrun = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output; after release a line held low SHALL be treated as a start edge only once rx_s reads 0 post-reset.
REQ-028 Reset deassertion SHALL be synchronized externally to aclk; block adds no reset synchronizer.

Verification (CLKS_PER_BIT = 16 in bench)
REQ-029 Send 0xA5, tready = 1 -> tvalid one cycle, tdata = 0xA5, frame_err = 0, overrun = 0.
REQ-030 Low glitch of 6 cycles on idle line -> FSM returns to IDLE, no tvalid, no frame_err.
REQ-031 Send 0x3C with stop bit low, line high after 20 cycles -> frame_err one pulse, no tvalid, next byte 0x81 received correctly.
REQ-032 tready = 0, send 0x11 then 0x22 -> tdata stays 0x11, overrun pulses once at second stop sample; raise tready -> 0x11 consumed, tvalid drops.
REQ-033 Back-to-back 0x55, 0xAA with tready pulsed exactly in the cycle 0xAA completes -> 0xAA loaded, tvalid stays high, no overrun.
REQ-034 aresetn low during DATA bit 4 of 0xF0 -> all outputs reset values, no tvalid after release; subsequent 0x0F received correctly.
